imem_loadable: RTL and testbench

//  Parametrised, clocked successor to the fixed-program instruction memory.

---
 rtl/imem_loadable.sv | 187 ++++++++++++++++++
 tb/tb_imem_loadable.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
//
// Instruction memory with a run-time program load port. Holds DEPTH words of
// IW bits, addressed by byte (bit 0 of iaddr is ignored). Reads have one cycle
// of registered latency and report validity / range errors alongside the data.
// While a load is in progress the memory is busy and fetches are dropped.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   fetch_req    fetch request for iaddr this cycle
//   iaddr        byte address of the instruction
//   idata        fetched instruction (registered)
//   idata_valid  idata holds the result of the previous cycle's fetch
//   addr_err     previous fetch was out of range (idata forced to 0)
//   ld_start     begin program load (one-cycle pulse, honoured in IDLE only)
//   ld_valid     ld_data is valid this cycle
//   ld_data      next program word
//   ld_ready     load port accepts a word this cycle
//   ld_done      one-cycle pulse on the edge that writes the last word
//   busy         load in progress; fetches are not serviced
//   dbg_state    current FSM state (0 = IDLE, 1 = LOAD)
//
// Load handshake: a word is transferred on a rising edge where both ld_valid
// and ld_ready are 1. ld_ready does not depend on ld_valid. The producer may
// hold ld_valid low for any number of cycles; the pointer and state hold
// meanwhile and there is no timeout. ld_valid outside LOAD writes nothing.
//
// Every output comes straight from a flop. ld_ready / busy are registered
// decodes of the next state, so they track the state register exactly.
// -----------------------------------------------------------------------------
module imem_loadable #(
   parameter int IW    = 17,
   parameter int AW    = 16,
   parameter int DEPTH = 8,
   parameter int LD    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fetch_req,
   input  logic [AW-1:0] iaddr,
   output logic [IW-1:0] idata,
   output logic          idata_valid,
   output logic          addr_err,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [IW-1:0] ld_data,
   output logic          ld_ready,
   output logic          ld_done,
   output logic          busy,
   output logic          dbg_state
);

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   localparam logic [LD-1:0] PTR_MAX = LD'(DEPTH - 1);

   state_t        state;
   state_t        state_nxt;
   logic [LD-1:0] ptr;
   logic [LD-1:0] ptr_nxt;

   logic          busy_nxt;
   logic          ld_ready_nxt;
   logic          ld_done_nxt;

   logic [IW-1:0] mem [DEPTH];

   logic          wr_en;
   logic [LD-1:0] rd_idx;
   logic          in_range;
   logic          unused_iaddr_bit0;

   // Instructions are half-word aligned; the low address bit carries nothing.
   assign unused_iaddr_bit0 = iaddr[0];

   assign wr_en     = (state == LOAD) && ld_valid;
   assign rd_idx    = iaddr[LD:1];
   assign in_range  = (iaddr[AW-1:LD+1] == '0);
   assign dbg_state = state;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (ld_start) begin
               state_nxt = LOAD;
               ptr_nxt   = '0;
            end
         end
         LOAD: begin
            // ld_start is deliberately ignored here so a stray pulse cannot
            // restart the pointer mid-program.
            if (ld_valid) begin
               if (ptr == PTR_MAX) begin
                  state_nxt = IDLE;
                  ptr_nxt   = '0;
               end else begin
                  ptr_nxt = ptr + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode (registered below so no input reaches an output combinationally)
   // ---------------------------------------------------------------------------
   always_comb begin
      busy_nxt     = (state_nxt == LOAD);
      ld_ready_nxt = (state_nxt == LOAD);
      ld_done_nxt  = wr_en && (ptr == PTR_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         ld_ready <= 1'b0;
         ld_done  <= 1'b0;
      end else begin
         busy     <= busy_nxt;
         ld_ready <= ld_ready_nxt;
         ld_done  <= ld_done_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Storage: contents survive reset, so a partially completed load leaves the
   // written words new and the rest old.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[ptr] <= ld_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Fetch path. Uses the current state, so a fetch coinciding with ld_start
   // is still serviced from the old contents. The last write and the first
   // post-load read land on different edges, so no bypass is needed.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idata       <= '0;
         idata_valid <= 1'b0;
         addr_err    <= 1'b0;
      end else if ((state == IDLE) && fetch_req) begin
         idata_valid <= 1'b1;
         if (in_range) begin
            idata    <= mem[rd_idx];
            addr_err <= 1'b0;
         end else begin
            idata    <= '0;
            addr_err <= 1'b1;
         end
      end else begin
         idata_valid <= 1'b0;
         addr_err    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_imem_loadable.sv
// -----------------------------------------------------------------------------
// tb_imem_loadable
//
// Directed bench for imem_loadable (DEPTH=8, IW=17, AW=16). A table of
// {inputs, expected outputs} records covers the first program load and the
// basic fetch patterns; hand-written sequences cover the load/fetch overlap,
// reset in the middle of a load, and a load with gaps and a stray ld_start.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_imem_loadable;

   localparam int IW = 17;
   localparam int AW = 16;

   logic          clk;
   logic          rst_n;
   logic          fetch_req;
   logic [AW-1:0] iaddr;
   logic [IW-1:0] idata;
   logic          idata_valid;
   logic          addr_err;
   logic          ld_start;
   logic          ld_valid;
   logic [IW-1:0] ld_data;
   logic          ld_ready;
   logic          ld_done;
   logic          busy;
   logic          dbg_state;

   int n_checks;
   int n_fail;

   imem_loadable #(.IW(IW), .AW(AW), .DEPTH(8), .LD(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_req   (fetch_req),
      .iaddr       (iaddr),
      .idata       (idata),
      .idata_valid (idata_valid),
      .addr_err    (addr_err),
      .ld_start    (ld_start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .ld_done     (ld_done),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic          fr;
      logic [AW-1:0] ia;
      logic          st;
      logic          lv;
      logic [IW-1:0] d;
      logic [IW-1:0] e_idata;
      logic          e_valid;
      logic          e_err;
      logic          e_ready;
      logic          e_busy;
      logic          e_done;
   } vec_t;

   vec_t vecs[$];

   // 3x5 program: fields {op[4:0], rs[3:0], rt[3:0], rd[3:0]}, padded with zeros.
   logic [IW-1:0] prog [8];
   logic [IW-1:0] exp_mem [8];

   // ---------------------------------------------------------------------------
   // Driver / checker tasks
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fr, input logic [AW-1:0] ia, input logic st,
                        input logic lv, input logic [IW-1:0] d);
      fetch_req = fr;
      iaddr     = ia;
      ld_start  = st;
      ld_valid  = lv;
      ld_data   = d;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic [IW-1:0] e_idata,
                          input logic e_valid, input logic e_err, input logic e_ready,
                          input logic e_busy, input logic e_done);
      chk({tag, ".idata"},       32'(idata),       32'(e_idata));
      chk({tag, ".idata_valid"}, 32'(idata_valid), 32'(e_valid));
      chk({tag, ".addr_err"},    32'(addr_err),    32'(e_err));
      chk({tag, ".ld_ready"},    32'(ld_ready),    32'(e_ready));
      chk({tag, ".busy"},        32'(busy),        32'(e_busy));
      chk({tag, ".ld_done"},     32'(ld_done),     32'(e_done));
   endtask

   task automatic add_vec(input logic fr, input logic [AW-1:0] ia, input logic st,
                          input logic lv, input logic [IW-1:0] d,
                          input logic [IW-1:0] e_idata, input logic e_valid,
                          input logic e_err, input logic e_ready,
                          input logic e_busy, input logic e_done);
      vec_t v;
      v.fr = fr;  v.ia = ia;  v.st = st;  v.lv = lv;  v.d = d;
      v.e_idata = e_idata;  v.e_valid = e_valid;  v.e_err = e_err;
      v.e_ready = e_ready;  v.e_busy = e_busy;    v.e_done = e_done;
      vecs.push_back(v);
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      int n_done;
      int gaps [8];
      logic [IW-1:0] old_word;

      n_checks = 0;
      n_fail   = 0;

      prog[0] = 17'h06023;  // {6,0,2,3}
      prog[1] = 17'h01003;  // add $3,$0,$0
      prog[2] = 17'h04312;  // beq
      prog[3] = 17'h10231;
      prog[4] = 17'h1C000;
      prog[5] = 17'h00000;
      prog[6] = 17'h00000;
      prog[7] = 17'h00000;

      // ---- Test 1-3 table ---------------------------------------------------
      //       fr ia        st lv d         idata     vl er rdy bsy dn
      add_vec(0, 16'h0000, 1, 0, 17'h0,    17'h0,     0, 0, 1,  1,  0);
      for (int i = 0; i < 8; i++)
         add_vec(0, 16'h0000, 0, 1, prog[i], 17'h0,   0, 0, (i < 7), (i < 7), (i == 7));
      add_vec(1, 16'h0000, 0, 0, 17'h0,    prog[0],   1, 0, 0,  0,  0);
      add_vec(1, 16'h0002, 0, 0, 17'h0,    prog[1],   1, 0, 0,  0,  0);
      add_vec(1, 16'h0005, 0, 0, 17'h0,    prog[2],   1, 0, 0,  0,  0);
      add_vec(1, 16'h0008, 0, 0, 17'h0,    prog[4],   1, 0, 0,  0,  0);
      add_vec(0, 16'h0000, 0, 0, 17'h0,    prog[4],   0, 0, 0,  0,  0);
      add_vec(1, 16'h0006, 0, 0, 17'h0,    prog[3],   1, 0, 0,  0,  0);
      add_vec(1, 16'h0010, 0, 0, 17'h0,    17'h0,     1, 1, 0,  0,  0);
      add_vec(0, 16'h0000, 0, 0, 17'h0,    17'h0,     0, 0, 0,  0,  0);
      add_vec(1, 16'hFFFE, 0, 0, 17'h0,    17'h0,     1, 1, 0,  0,  0);
      add_vec(1, 16'h000F, 0, 0, 17'h0,    prog[7],   1, 0, 0,  0,  0);
      add_vec(0, 16'h0000, 0, 0, 17'h0,    prog[7],   0, 0, 0,  0,  0);

      // ---- Reset ------------------------------------------------------------
      rst_n = 1'b0;
      drive(0, 16'h0000, 0, 0, 17'h0);
      tick();
      tick();
      chk_out("reset", 17'h0, 0, 0, 0, 0, 0);
      chk("reset.dbg_state", 32'(dbg_state), 32'd0);
      rst_n = 1'b1;

      // ---- Table ------------------------------------------------------------
      foreach (vecs[k]) begin
         drive(vecs[k].fr, vecs[k].ia, vecs[k].st, vecs[k].lv, vecs[k].d);
         tick();
         chk_out($sformatf("vec%0d", k), vecs[k].e_idata, vecs[k].e_valid,
                 vecs[k].e_err, vecs[k].e_ready, vecs[k].e_busy, vecs[k].e_done);
      end

      // ---- Test 4: fetch together with ld_start, then load all-ones --------
      drive(1, 16'h0000, 1, 0, 17'h0);
      tick();
      chk_out("t4_overlap", prog[0], 1, 0, 1, 1, 0);
      chk("t4_overlap.dbg_state", 32'(dbg_state), 32'd1);
      for (int i = 0; i < 8; i++) begin
         drive(1, (i == 3) ? 16'h0010 : 16'(2 * i), 0, 1, 17'h1FFFF);
         tick();
         chk_out($sformatf("t4_beat%0d", i), prog[0], 0, 0, (i < 7), (i < 7), (i == 7));
      end
      drive(1, 16'h0000, 0, 0, 17'h0);
      tick();
      chk_out("t4_new0", 17'h1FFFF, 1, 0, 0, 0, 0);
      drive(1, 16'h000E, 0, 0, 17'h0);
      tick();
      chk_out("t4_new7", 17'h1FFFF, 1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) exp_mem[i] = 17'h1FFFF;

      // ---- Test 5: reset in the middle of a load ---------------------------
      drive(0, 16'h0000, 1, 0, 17'h0);
      tick();
      chk_out("t5_start", 17'h1FFFF, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 16'h0000, 0, 1, 17'(17'h0AAA0 + i));
         tick();
         chk_out($sformatf("t5_beat%0d", i), 17'h1FFFF, 0, 0, 1, 1, 0);
         exp_mem[i] = 17'(17'h0AAA0 + i);
      end
      drive(0, 16'h0000, 0, 0, 17'h0);
      rst_n = 1'b0;
      #1;
      chk_out("t5_async_rst", 17'h0, 0, 0, 0, 0, 0);
      chk("t5_async_rst.dbg_state", 32'(dbg_state), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 16'(2 * i), 0, 0, 17'h0);
         tick();
         chk_out($sformatf("t5_fetch%0d", i), exp_mem[i], 1, 0, 0, 0, 0);
      end

      // ---- Test 6: gaps and a stray ld_start mid-load ----------------------
      gaps[0] = 1; gaps[1] = 2; gaps[2] = 3; gaps[3] = 4;
      gaps[4] = 2; gaps[5] = 1; gaps[6] = 4; gaps[7] = 3;
      n_done = 0;
      drive(0, 16'h0000, 1, 0, 17'h0);
      tick();
      chk("t6_start.busy", 32'(busy), 32'd1);
      old_word = idata;
      for (int w = 0; w < 8; w++) begin
         for (int g = 0; g < gaps[w]; g++) begin
            drive(1, 16'h0000, (w == 4 && g == 0), 0, 17'h1ABCD);
            tick();
            n_done += int'(ld_done);
            chk_out($sformatf("t6_gap%0d_%0d", w, g), old_word, 0, 0, 1, 1, 0);
         end
         drive(0, 16'h0000, (w == 6), 1, 17'(17'h00100 + 3 * w));
         tick();
         n_done += int'(ld_done);
         chk_out($sformatf("t6_beat%0d", w), old_word, 0, 0, (w < 7), (w < 7), (w == 7));
         exp_mem[w] = 17'(17'h00100 + 3 * w);
      end
      drive(0, 16'h0000, 0, 0, 17'h0);
      tick();
      n_done += int'(ld_done);
      chk("t6_done_count", 32'(n_done), 32'd1);
      chk("t6_idle.ld_done", 32'(ld_done), 32'd0);

      // ld_valid in IDLE must not write
      drive(0, 16'h0000, 0, 1, 17'h15555);
      tick();
      chk("t6_idle_valid.ld_ready", 32'(ld_ready), 32'd0);
      for (int i = 0; i < 8; i++) begin
         drive(1, 16'(2 * i), 0, 0, 17'h0);
         tick();
         chk_out($sformatf("t6_fetch%0d", i), exp_mem[i], 1, 0, 0, 0, 0);
      end

      drive(0, 16'h0000, 0, 0, 17'h0);
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
